data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Data-memory responder for the five-stage pipeline: it answers the data SRAM requests issued by EX and drives `data_sram_rdata` one cycle later, in time for the MEM stage to select it as load result. It holds a word-addressed RAM with per-byte write enables. An optional wait-state generator raises a stall request toward the stall controller so that slower memory timing can be modelled without changing the pipeline stages.

## Interface
- `ADDR_W`, default 10: word-index width; RAM depth is 2^ADDR_W words of 32 bits.
- `WAIT_CYCLES`, default 0: extra stall cycles per access, legal range 0..15.

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `data_sram_en`  in  1  access request from EX
- `data_sram_wen`  in  4  byte write enables; 0 means read, nonzero means write
- `data_sram_addr`  in  32  byte address
- `data_sram_wdata`  in  32  store data, byte i on bits [8i+7:8i]
- `data_sram_rdata`  out  32  load data to MEM, registered
- `stallreq_mem`  out  1  stall request to the stall controller, combinational

## Operation
- Word index is `data_sram_addr[ADDR_W+1:2]`.
  - `addr[1:0]` and the bits above `ADDR_W+1` are ignored, so upper addresses alias.
- When `data_sram_en`=0, no action is taken, whatever the value of `data_sram_wen`.
- Write: for each i with `wen[i]`=1, byte i of the addressed word takes `wdata[8i+7:8i]`. Other bytes are unchanged. `rdata` holds its value.
- Read: `rdata` takes `mem[index]` at the access edge and holds until the next read access.
- A write and a read are never both issued in one cycle (single port).
- A read following a write to the same word on the next access returns the written data.
- The RAM contents are not reset. Benches must write a location before reading it.
- The FSM has two states, IDLE and BUSY, with a 4-bit counter `cnt`.
  - IDLE, `en`=0: stay IDLE; `stallreq_mem`=0.
  - IDLE, `en`=1, `WAIT_CYCLES`=0: perform the access at this edge; stay IDLE; `stallreq_mem`=0.
  - IDLE, `en`=1, `WAIT_CYCLES`=N>0:
    - `stallreq_mem`=1 this cycle.
    - At the edge, latch addr, wen and wdata, set `cnt`=N-1, and go to BUSY.
    - No RAM access happens at this edge.
  - BUSY, `cnt`≠0: `stallreq_mem`=1; `cnt` decrements.
  - BUSY, `cnt`=0:
    - `stallreq_mem`=0.
    - At the edge, perform the access using the latched request, then go to IDLE.
    - Live inputs are ignored throughout BUSY.
- Total stall per access is exactly N cycles. The request is presented for N+1 cycles, and data is visible in the cycle after the access edge.
- Reset asserted in any state:
  - The state goes to IDLE, `cnt`=0, `stallreq_mem`=0 and `rdata`=0 immediately, without waiting for a clock edge.
  - A pending latched access is dropped and no write occurs.

## Timing
- Reset values: `data_sram_rdata`=32'h0, `stallreq_mem`=0, state IDLE, `cnt`=0.
- Read latency with `WAIT_CYCLES`=0: request in cycle T, data valid in T+1 and held until the next read.
- Read latency with `WAIT_CYCLES`=N: request in T, `stallreq_mem` high during T..T+N-1, access edge at the end of T+N, data valid in T+N+1.
- Write takes effect at the access edge. A read whose access edge is later sees the new data.
- `stallreq_mem` depends only on the state, `cnt` and `data_sram_en`. It has no path from `addr` or `wdata`.
- Back-to-back accesses with `WAIT_CYCLES`=0 run at one per cycle.
- With `WAIT_CYCLES`>0, a new request is evaluated in the first IDLE cycle after BUSY.

## Test plan
- Reset release, then `WAIT_CYCLES`=0:
  - write `wen`=4'hF, addr 0x40, wdata 0xDEADBEEF
  - next cycle read addr 0x40
  - required: rdata=0xDEADBEEF one cycle after the read; stallreq_mem stays 0.
- Byte lanes: word 0x40 holds 0xDEADBEEF; write `wen`=4'b0101 with wdata 0x11223344, then read.
  - required: rdata=0xDE22BE44.
- Hold and aliasing:
  - read addr 0x40, then idle cycles with `en`=0 and `wen`=4'hF
    - required: rdata stays constant and the memory is unchanged.
  - read addr 0x40 | (1<<(ADDR_W+2)) | 0x3
    - required: the same word is returned.
- Wait states, `WAIT_CYCLES`=3:
  - setup: write 0xCAFEF00D to addr 0x80 with `en`=1 held.
    - required: stallreq_mem high for exactly 3 cycles, then 0.
  - change addr/wdata during BUSY.
    - required: the latched values are the ones written.
  - read back.
    - required: 3 more stall cycles, then rdata=0xCAFEF00D in the cycle after stallreq_mem falls.
- Reset mid-operation, `WAIT_CYCLES`=3:
  - write 0x12345678 to addr 0x84, which holds 0x0; assert `rst` asynchronously during the second BUSY cycle.
    - required: stallreq_mem=0 and rdata=0 before the next clock edge.
  - read addr 0x84.
    - required: 0x00000000, confirming the dropped write.

Source files
------------

// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Data-memory responder for the five-stage pipeline. Accepts data SRAM
// requests issued by EX and returns registered load data one cycle after the
// access edge, in time for MEM to select it as the load result. The memory is
// a word-addressed RAM of 2^ADDR_W 32-bit words with per-byte write enables.
// With WAIT_CYCLES = N > 0, every access is held for N stall cycles before it
// is performed, so slower memory timing can be modelled without touching the
// pipeline stages.
//
// Parameters:
//   ADDR_W       word-index width; RAM depth is 2^ADDR_W words
//   WAIT_CYCLES  extra stall cycles per access, 0..15
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   data_sram_en     access request from EX
//   data_sram_wen    byte write enables (0 = read, nonzero = write)
//   data_sram_addr   byte address; word index is addr[ADDR_W+1:2]
//   data_sram_wdata  store data, byte i on bits [8i+7:8i]
//   data_sram_rdata  registered load data, held until the next read
//   stallreq_mem     combinational stall request to the stall controller
// -----------------------------------------------------------------------------
module data_sram_resp #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_mem
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          req_wen_q, req_wen_d;
    logic [ADDR_W-1:0]   req_idx_q, req_idx_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];

    // Access performed at the coming edge, either from the live request
    // (zero wait states) or from the request latched when BUSY was entered.
    logic                acc_en;
    logic [3:0]          acc_wen;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wdata;
    logic                stallreq;

    logic [ADDR_W-1:0]   live_idx;
    logic                unused_addr;

    // Byte offset and bits above the word index are ignored: upper addresses
    // alias onto the same RAM.
    assign live_idx    = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_wen_d   = req_wen_q;
        req_idx_d   = req_idx_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        acc_en      = 1'b0;
        acc_wen     = data_sram_wen;
        acc_idx     = live_idx;
        acc_wdata   = data_sram_wdata;
        stallreq    = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    if (WAIT_CYCLES == 0) begin
                        acc_en = 1'b1;
                    end else begin
                        // Capture the request now; the RAM is touched only
                        // once the wait count has expired.
                        stallreq    = 1'b1;
                        state_d     = BUSY;
                        cnt_d       = 4'(WAIT_N - 4'd1);
                        req_wen_d   = data_sram_wen;
                        req_idx_d   = live_idx;
                        req_wdata_d = data_sram_wdata;
                    end
                end
            end
            BUSY: begin
                // Live inputs are ignored for the whole BUSY phase.
                if (cnt_q != 4'd0) begin
                    stallreq = 1'b1;
                    cnt_d    = 4'(cnt_q - 4'd1);
                end else begin
                    acc_en    = 1'b1;
                    acc_wen   = req_wen_q;
                    acc_idx   = req_idx_q;
                    acc_wdata = req_wdata_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc_en && (acc_wen == 4'd0)) begin
            rdata_d = mem[acc_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_wen_q   <= 4'd0;
            req_idx_q   <= '0;
            req_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_wen_q   <= req_wen_d;
            req_idx_q   <= req_idx_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto a plain memory macro.
    // A latched access pending at reset is dropped because reset forces the
    // state to IDLE, which removes the BUSY-side access enable.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign stallreq_mem    = stallreq;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//
// Directed bench for data_sram_resp. Two instances share clk and rst:
// u_dut0 runs with no wait states, u_dut3 with three. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

    localparam int unsigned ADDR_W = 10;

    logic        clk;
    logic        rst;

    logic        a_en;
    logic [3:0]  a_wen;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_stall;

    logic        b_en;
    logic [3:0]  b_wen;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        b_stall;

    int n_total = 0;
    int n_bad   = 0;

    data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (a_en),
        .data_sram_wen   (a_wen),
        .data_sram_addr  (a_addr),
        .data_sram_wdata (a_wdata),
        .data_sram_rdata (a_rdata),
        .stallreq_mem    (a_stall)
    );

    data_sram_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (b_en),
        .data_sram_wen   (b_wen),
        .data_sram_addr  (b_addr),
        .data_sram_wdata (b_wdata),
        .data_sram_rdata (b_rdata),
        .stallreq_mem    (b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic en, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
        a_en    = en;
        a_wen   = wen;
        a_addr  = addr;
        a_wdata = wdata;
    endtask

    // One access on the wait-state instance: stall must be high for exactly
    // three cycles, then low for the access cycle. Address and data are
    // disturbed during BUSY to prove the latched copy is used.
    task automatic b_access(input string tag, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
        b_en    = 1'b1;
        b_wen   = wen;
        b_addr  = addr;
        b_wdata = wdata;
        #1;
        check({tag, "_stall_t0"}, 32'(b_stall), 32'd1);
        tick();
        b_addr  = addr ^ 32'h0000_0008;
        b_wdata = ~wdata;
        b_wen   = 4'hF;
        check({tag, "_stall_t1"}, 32'(b_stall), 32'd1);
        tick();
        check({tag, "_stall_t2"}, 32'(b_stall), 32'd1);
        tick();
        check({tag, "_stall_t3"}, 32'(b_stall), 32'd0);
        b_en = 1'b0;
        tick();
        check({tag, "_stall_after"}, 32'(b_stall), 32'd0);
    endtask

    logic [31:0] alias_addr;

    initial begin
        rst = 1'b1;
        a_drive(1'b0, 4'h0, 32'h0, 32'h0);
        b_en = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
        #12;
        check("rst_rdata0", a_rdata, 32'h0);
        check("rst_stall0", 32'(a_stall), 32'd0);
        check("rst_rdata3", b_rdata, 32'h0);
        check("rst_stall3", 32'(b_stall), 32'd0);
        #2;
        rst = 1'b0;
        tick();

        // ---------------- zero wait states ----------------
        a_drive(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        #1;
        check("w0_write_stall", 32'(a_stall), 32'd0);
        tick();
        a_drive(1'b1, 4'h0, 32'h40, 32'h0);
        #1;
        check("w0_read_stall", 32'(a_stall), 32'd0);
        tick();
        check("w0_read_data", a_rdata, 32'hDEADBEEF);

        // Byte-lane write; rdata must hold across the write.
        a_drive(1'b1, 4'b0101, 32'h40, 32'h11223344);
        tick();
        check("lane_hold_on_write", a_rdata, 32'hDEADBEEF);
        a_drive(1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        check("lane_merge", a_rdata, 32'hDE22BE44);

        // Idle cycles with wen set must neither write nor disturb rdata.
        a_drive(1'b0, 4'hF, 32'h40, 32'h55AA55AA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_hold_%0d", i), a_rdata, 32'hDE22BE44);
        end

        // Back-to-back write, write, read, read at one per cycle.
        a_drive(1'b1, 4'hF, 32'h44, 32'h01020304);
        tick();
        a_drive(1'b1, 4'hF, 32'h48, 32'hA0B0C0D0);
        tick();
        a_drive(1'b1, 4'h0, 32'h44, 32'h0);
        tick();
        check("b2b_read_44", a_rdata, 32'h01020304);
        a_drive(1'b1, 4'h0, 32'h48, 32'h0);
        tick();
        check("b2b_read_48", a_rdata, 32'hA0B0C0D0);

        // Aliased address returns the unchanged word at 0x40.
        alias_addr = 32'h40 | (32'd1 << (ADDR_W + 2)) | 32'h3;
        a_drive(1'b1, 4'h0, alias_addr, 32'h0);
        tick();
        check("alias_read", a_rdata, 32'hDE22BE44);
        a_drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // ---------------- three wait states ----------------
        b_access("ws_write", 4'hF, 32'h80, 32'hCAFEF00D);
        check("ws_write_rdata_hold", b_rdata, 32'h0);

        // Read back: data must not appear before the access edge.
        b_en = 1'b1; b_wen = 4'h0; b_addr = 32'h80; b_wdata = 32'h0;
        #1;
        check("ws_read_stall_t0", 32'(b_stall), 32'd1);
        tick();
        check("ws_read_stall_t1", 32'(b_stall), 32'd1);
        tick();
        check("ws_read_stall_t2", 32'(b_stall), 32'd1);
        tick();
        check("ws_read_stall_t3", 32'(b_stall), 32'd0);
        check("ws_read_early", b_rdata, 32'h0);
        b_en = 1'b0;
        tick();
        check("ws_read_data", b_rdata, 32'hCAFEF00D);

        // Initialise 0x84 to zero, then reload a non-zero rdata.
        b_access("init84", 4'hF, 32'h84, 32'h0);
        b_access("reread80", 4'h0, 32'h80, 32'h0);
        check("reread80_data", b_rdata, 32'hCAFEF00D);

        // Write to 0x84, reset asynchronously in the second BUSY cycle.
        b_en = 1'b1; b_wen = 4'hF; b_addr = 32'h84; b_wdata = 32'h12345678;
        tick();
        check("rstmid_busy1_stall", 32'(b_stall), 32'd1);
        tick();
        check("rstmid_busy2_stall", 32'(b_stall), 32'd1);
        b_en = 1'b0;
        rst  = 1'b1;
        #1;
        check("rstmid_async_stall", 32'(b_stall), 32'd0);
        check("rstmid_async_rdata", b_rdata, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check("rstmid_idle_stall", 32'(b_stall), 32'd0);

        b_access("read84", 4'h0, 32'h84, 32'h0);
        check("read84_dropped", b_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
